// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the divided-clock bank.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package clk_gen_pkg;

  // Per-channel phase of the divided clock.
  typedef enum logic [1:0] {
    STOP = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chan_state_e;

  // Channel-index width, never narrower than one bit so a single-channel
  // bank still has a legal cfg_idx port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One divided-clock channel: STOP/HIGH/LOW FSM, down-counter and divisor.
// Latency: clk_out rises one cycle after en is sampled in STOP.
// Backpressure: takes the pending divisor only in STOP or at a period boundary.
module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             apply,
  input  logic [DIV_W-1:0] pend_div,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             consumed
);

  chan_state_e      state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_reg;
  logic             at_boundary;
  logic [DIV_W-1:0] div_next;

  // A full period ends when the LOW phase has counted out; only then (or
  // while idle) may the divisor change, so no period is ever shortened.
  assign at_boundary = (state == LOW) && (cnt == '0);
  assign consumed    = apply && ((state == STOP) || at_boundary);
  assign div_next    = consumed ? pend_div : div_reg;
  assign running     = (state != STOP);

  // Phase sequencing; clk_out and tick come straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STOP;
      cnt     <= '0;
      div_reg <= DIV_RST;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (consumed) div_reg <= pend_div;
      case (state)
        STOP: begin
          clk_out <= 1'b0;
          if (en) begin
            clk_out <= 1'b1;
            tick    <= 1'b1;
            cnt     <= div_next;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            clk_out <= 1'b0;
            cnt     <= div_reg;
            state   <= LOW;
          end
        end
        LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (en) begin
            clk_out <= 1'b1;
            tick    <= 1'b1;
            cnt     <= div_next;
            state   <= HIGH;
          end else begin
            clk_out <= 1'b0;
            state   <= STOP;
          end
        end
        default: begin
          clk_out <= 1'b0;
          state   <= STOP;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_gen_bank.sv
// Bank of N divided clocks from one reference, with a single pending cfg slot.
// Latency: cfg accepted -> applied next cycle if target stopped, else at its next period boundary.
// Backpressure: cfg_ready low while the pending slot holds an unapplied divisor.
module clk_gen_bank
  import clk_gen_pkg::*;
#(
  parameter int N       = 4,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [idx_width(N)-1:0]   cfg_idx,
  input  logic [DIV_W-1:0]          cfg_div,
  output logic                      cfg_err,
  output logic [N-1:0]              clk_out,
  output logic [N-1:0]              tick,
  output logic [N-1:0]              running
);

  localparam int CFG_IDX_W = idx_width(N);

  logic                 pend_vld;
  logic [CFG_IDX_W-1:0] pend_idx;
  logic [DIV_W-1:0]     pend_div;
  logic [N-1:0]         consumed;
  logic                 accept;
  logic                 idx_ok;

  // Extra compare bit so N itself is representable when N is a power of two.
  assign idx_ok    = {1'b0, cfg_idx} < (CFG_IDX_W + 1)'(N);
  assign cfg_ready = !pend_vld;
  assign accept    = cfg_valid && cfg_ready;

  // Pending slot: filled on an in-range accept, emptied when its channel takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_idx <= '0;
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= accept && !idx_ok;
      if (accept && idx_ok) begin
        pend_vld <= 1'b1;
        pend_idx <= cfg_idx;
        pend_div <= cfg_div;
      end else if (|consumed) begin
        pend_vld <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    clk_gen_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_W'(DIV_RST))
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .apply    (pend_vld && (pend_idx == CFG_IDX_W'(i))),
      .pend_div (pend_div),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .running  (running[i]),
      .consumed (consumed[i])
    );
  end

endmodule

// File: tb/tb_clk_gen_bank.sv
// Directed bench for clk_gen_bank: vector table plus multi-cycle sequences.
// Latency: checks sampled on the negedge following each driven posedge.
// Backpressure: cfg_ready is checked, never waited on.
module tb_clk_gen_bank;

  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_div;
  logic       cfg_err;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [3:0] running;

  // Three-channel instance: lets an out-of-range index (3) be expressed.
  logic [2:0] e_en;
  logic       e_cfg_valid;
  logic       e_cfg_ready;
  logic [1:0] e_cfg_idx;
  logic [7:0] e_cfg_div;
  logic       e_cfg_err;
  logic [2:0] e_clk_out;
  logic [2:0] e_tick;
  logic [2:0] e_running;

  int errors = 0;
  int checks = 0;

  clk_gen_bank #(.N(4), .DIV_W(8), .DIV_RST(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_div(cfg_div), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick), .running(running)
  );

  clk_gen_bank #(.N(3), .DIV_W(8), .DIV_RST(0)) u_dut3 (
    .clk(clk), .rst(rst), .en(e_en), .cfg_valid(e_cfg_valid), .cfg_ready(e_cfg_ready),
    .cfg_idx(e_cfg_idx), .cfg_div(e_cfg_div), .cfg_err(e_cfg_err),
    .clk_out(e_clk_out), .tick(e_tick), .running(e_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] en;
    logic       v;
    logic [1:0] idx;
    logic [7:0] d;
    logic [3:0] co;
    logic [3:0] tk;
    logic [3:0] run;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, let one posedge consume it, return at the next negedge.
  task automatic step(input logic [3:0] e, input logic v, input logic [1:0] idx, input logic [7:0] d);
    en        = e;
    cfg_valid = v;
    cfg_idx   = idx;
    cfg_div   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = '0; cfg_valid = 1'b0; cfg_idx = '0; cfg_div = '0;
    e_en = '0; e_cfg_valid = 1'b0; e_cfg_idx = '0; e_cfg_div = '0;

    // en, v, idx, div | clk_out, tick, running, ready, err
    tbl[0]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[2]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0};
    tbl[3]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 1'b1, 2'd1, 8'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0};
    tbl[7]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[8]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[9]  = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[10] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[11] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[12] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[14] = '{4'b0010, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0};

    @(negedge clk);
    do_reset();
    chk("reset clk_out", 32'(clk_out), 32'h0);
    chk("reset tick", 32'(tick), 32'h0);
    chk("reset running", 32'(running), 32'h0);
    chk("reset cfg_ready", 32'(cfg_ready), 32'h1);
    chk("reset cfg_err", 32'(cfg_err), 32'h0);

    // clk/2 on ch0, then stopped-channel divisor load and div=3 on ch1.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].idx, tbl[i].d);
      chk($sformatf("vec%0d clk_out", i), 32'(clk_out), 32'(tbl[i].co));
      chk($sformatf("vec%0d tick", i), 32'(tick), 32'(tbl[i].tk));
      chk($sformatf("vec%0d running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("vec%0d cfg_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d cfg_err", i), 32'(cfg_err), 32'(tbl[i].err));
    end

    // ch2 at div=2, retarget to div=5 mid-HIGH: 3/3 period finishes, then 6/6.
    do_reset();
    step(4'b0000, 1'b1, 2'd2, 8'd2);
    step(4'b0100, 1'b0, 2'd0, 8'd0);
    chk("ch2 start clk_out", 32'(clk_out[2]), 32'h1);
    for (int s = 1; s <= 18; s++) begin
      logic ec, et, er;
      step(4'b0100, (s == 1), 2'd2, 8'd5);
      ec = (s <= 2) || (s >= 6 && s <= 11) || (s == 18);
      et = (s == 6) || (s == 18);
      er = !(s >= 1 && s <= 5);
      chk($sformatf("ch2 s%0d clk_out", s), 32'(clk_out[2]), 32'(ec));
      chk($sformatf("ch2 s%0d tick", s), 32'(tick[2]), 32'(et));
      chk($sformatf("ch2 s%0d cfg_ready", s), 32'(cfg_ready), 32'(er));
    end

    // ch0 at div=4, en dropped one cycle after rising: full 5/5 period, then STOP.
    do_reset();
    step(4'b0000, 1'b1, 2'd0, 8'd4);
    step(4'b0001, 1'b0, 2'd0, 8'd0);
    chk("ch0 start clk_out", 32'(clk_out[0]), 32'h1);
    for (int s = 1; s <= 12; s++) begin
      step(4'b0000, 1'b0, 2'd0, 8'd0);
      chk($sformatf("ch0 s%0d clk_out", s), 32'(clk_out[0]), 32'(s <= 4));
      chk($sformatf("ch0 s%0d running", s), 32'(running[0]), 32'(s <= 9));
      chk($sformatf("ch0 s%0d tick", s), 32'(tick[0]), 32'h0);
    end

    // Reset while an update is pending and every channel runs.
    do_reset();
    step(4'b0000, 1'b1, 2'd3, 8'd6);
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    step(4'b1111, 1'b0, 2'd0, 8'd0);
    step(4'b1111, 1'b1, 2'd3, 8'd2);
    chk("pre-rst cfg_ready", 32'(cfg_ready), 32'h0);
    chk("pre-rst running", 32'(running), 32'hf);
    rst = 1'b1;
    step(4'b1111, 1'b0, 2'd0, 8'd0);
    rst = 1'b0;
    chk("mid-rst clk_out", 32'(clk_out), 32'h0);
    chk("mid-rst running", 32'(running), 32'h0);
    chk("mid-rst cfg_ready", 32'(cfg_ready), 32'h1);
    chk("mid-rst tick", 32'(tick), 32'h0);
    step(4'b1000, 1'b0, 2'd0, 8'd0);
    chk("post-rst ch3 rise", 32'(clk_out), 32'h8);
    step(4'b1000, 1'b0, 2'd0, 8'd0);
    chk("post-rst ch3 fall", 32'(clk_out), 32'h0);
    step(4'b1000, 1'b0, 2'd0, 8'd0);
    chk("post-rst ch3 rise2", 32'(clk_out), 32'h8);
    chk("post-rst ch3 tick2", 32'(tick), 32'h8);
    chk("post-rst cfg_ready", 32'(cfg_ready), 32'h1);

    // Out-of-range index on the three-channel bank.
    do_reset();
    chk("n3 reset cfg_ready", 32'(e_cfg_ready), 32'h1);
    e_cfg_valid = 1'b1; e_cfg_idx = 2'd3; e_cfg_div = 8'd9;
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    chk("n3 cfg_err pulse", 32'(e_cfg_err), 32'h1);
    chk("n3 cfg_ready after bad idx", 32'(e_cfg_ready), 32'h1);
    e_cfg_valid = 1'b0; e_en = 3'b111;
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    chk("n3 cfg_err cleared", 32'(e_cfg_err), 32'h0);
    chk("n3 clk_out rise", 32'(e_clk_out), 32'h7);
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    chk("n3 clk_out fall", 32'(e_clk_out), 32'h0);
    step(4'b0000, 1'b0, 2'd0, 8'd0);
    chk("n3 clk_out rise2", 32'(e_clk_out), 32'h7);
    chk("n3 tick rise2", 32'(e_tick), 32'h7);
    chk("n3 running", 32'(e_running), 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
